// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: state encoding, pc_src codes and opcodes.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        SEQ_RESET,
        FETCH1,
        FETCH2,
        WAIT,
        IRQ
    } seq_state_e;

    localparam logic [1:0] PCSRC_REX = 2'b00;
    localparam logic [1:0] PCSRC_VEC = 2'b01;
    localparam logic [1:0] PCSRC_RD  = 2'b10;
    localparam logic [1:0] PCSRC_MEM = 2'b11;

    localparam logic [3:0] OPC_BR          = 4'd11;
    localparam logic [3:0] EXT_OPC_DEFAULT = 4'd12;

    // A single source still needs a 1-bit index.
    function automatic int irq_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Decode/control bundle between the decode stage (master) and the PC sequencer (slave).
interface pc_seq_if #(
    parameter int NUM_IRQ = 4
);
    localparam int AW = $clog2(NUM_IRQ + 2);

    logic [NUM_IRQ-1:0] irq;
    logic               irq_en;
    logic               stall_in;
    logic [3:0]         opcode;
    logic [1:0]         brx;
    logic               branch_taken;
    logic               bypass_decode_done;

    logic               pc_en;
    logic               pc_load;
    logic               stall;
    logic               sf1;
    logic [1:0]         pc_src;
    logic [AW-1:0]      addr_src;
    logic [NUM_IRQ-1:0] int_ack;

    modport master (
        output irq, irq_en, stall_in, opcode, brx, branch_taken, bypass_decode_done,
        input  pc_en, pc_load, stall, sf1, pc_src, addr_src, int_ack
    );

    modport slave (
        input  irq, irq_en, stall_in, opcode, brx, branch_taken, bypass_decode_done,
        output pc_en, pc_load, stall, sf1, pc_src, addr_src, int_ack
    );
endinterface

// File: rtl/pc_seq_irq_arb.sv
// Lowest-index-first priority encoder: pending vector -> one-hot grant and index.
module pc_seq_irq_arb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    // Two's-complement trick isolates the lowest set bit.
    assign gnt = req & (~req + N'(1));

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) idx = IW'(i);
    end
endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: fetch / branch / return-wait / interrupt-entry control.
// Optional PC_SEQ_PERF_CNT_EN adds a saturating stall-cycle counter port.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int         NUM_IRQ     = 4,
    parameter int         WAIT_CYCLES = 2,
    parameter logic [3:0] EXT_OPC     = EXT_OPC_DEFAULT
) (
    input logic     clk,
    input logic     reset,
    pc_seq_if.slave bus
`ifdef PC_SEQ_PERF_CNT_EN
    ,
    output logic [15:0] perf_stall_cnt
`endif
);
    localparam int AW = $clog2(NUM_IRQ + 2);
    localparam int IW = irq_idx_w(NUM_IRQ);

    seq_state_e         state, nxt;
    logic [NUM_IRQ-1:0] pend, gnt;
    logic [IW-1:0]      k;
    logic [2:0]         wcnt;
    logic               loaded_q;
    logic               is_ret, is_jmp, wait_done;

    pc_seq_irq_arb #(.N(NUM_IRQ), .IW(IW)) u_arb (
        .req (pend),
        .gnt (gnt),
        .idx (k)
    );

    assign is_ret    = (bus.opcode == OPC_BR) &&  bus.brx[1];
    assign is_jmp    = (bus.opcode == OPC_BR) && !bus.brx[1];
    assign wait_done = !bus.stall_in && (wcnt == 3'(WAIT_CYCLES - 1));

    always_comb begin
        bus.pc_en    = 1'b0;
        bus.pc_load  = 1'b0;
        bus.stall    = 1'b0;
        bus.sf1      = 1'b0;
        bus.pc_src   = PCSRC_REX;
        bus.addr_src = '0;
        bus.int_ack  = '0;
        nxt          = state;
        case (state)
            SEQ_RESET: begin
                bus.pc_en    = 1'b1;
                bus.pc_load  = 1'b1;
                bus.pc_src   = PCSRC_VEC;
                bus.addr_src = AW'(1);
                nxt          = FETCH1;
            end
            FETCH1: begin
                if (bus.branch_taken) begin
                    bus.pc_en   = 1'b1;
                    bus.pc_load = 1'b1;
                    bus.pc_src  = PCSRC_REX;
                end else if (is_ret) begin
                    bus.stall = 1'b1;
                    nxt       = WAIT;
                end else if (is_jmp) begin
                    if (bus.bypass_decode_done) begin
                        bus.pc_en   = 1'b1;
                        bus.pc_load = 1'b1;
                        bus.pc_src  = PCSRC_RD;
                    end else begin
                        bus.stall = 1'b1;
                    end
                end else if (bus.irq_en && (|pend)) begin
                    nxt = IRQ;
                end else begin
                    // The PC was just loaded, so it already points at the next fetch.
                    bus.pc_en = !loaded_q;
                    if (bus.opcode == EXT_OPC) nxt = FETCH2;
                end
            end
            FETCH2: begin
                bus.pc_en = 1'b1;
                nxt       = FETCH1;
            end
            WAIT: begin
                bus.stall = 1'b1;
                if (wait_done) begin
                    bus.pc_en   = 1'b1;
                    bus.pc_load = 1'b1;
                    bus.pc_src  = PCSRC_MEM;
                    bus.stall   = 1'b0;
                    nxt         = FETCH1;
                end
            end
            IRQ: begin
                bus.pc_en    = 1'b1;
                bus.pc_load  = 1'b1;
                bus.pc_src   = PCSRC_VEC;
                bus.addr_src = AW'(2) + AW'(k);
                bus.sf1      = 1'b1;
                bus.int_ack  = gnt;
                nxt          = FETCH1;
            end
            default: nxt = SEQ_RESET;
        endcase
        // Downstream stall freezes fetch; requests are simply re-decoded next cycle.
        if (bus.stall_in && (state == FETCH1 || state == FETCH2)) begin
            bus.pc_en   = 1'b0;
            bus.pc_load = 1'b0;
            nxt         = state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= SEQ_RESET;
            pend     <= '0;
            wcnt     <= '0;
            loaded_q <= 1'b0;
        end else begin
            state    <= nxt;
            pend     <= (pend & ~bus.int_ack) | bus.irq;
            loaded_q <= bus.pc_load;
            if (state == WAIT && !bus.stall_in)
                wcnt <= wait_done ? 3'd0 : wcnt + 3'd1;
        end
    end

`ifdef PC_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            perf_stall_cnt <= '0;
        else if (bus.stall && perf_stall_cnt != 16'hFFFF)
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random traffic vs a reference model.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int NI = 4;
    localparam int WC = 2;
    localparam int AW = $clog2(NI + 2);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pc_seq_if #(.NUM_IRQ(NI)) b();
`ifdef PC_SEQ_PERF_CNT_EN
    logic [15:0] perf;
`endif

    pc_sequencer #(.NUM_IRQ(NI), .WAIT_CYCLES(WC), .EXT_OPC(4'd12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
`ifdef PC_SEQ_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf)
`endif
    );

    typedef struct packed {
        logic          rst;
        logic [NI-1:0] irq;
        logic          irq_en;
        logic          stall_in;
        logic [3:0]    opcode;
        logic [1:0]    brx;
        logic          bt;
        logic          byp;
    } stim_t;

    typedef struct packed {
        logic          pc_en;
        logic          pc_load;
        logic          stall;
        logic          sf1;
        logic [1:0]    pc_src;
        logic [AW-1:0] addr_src;
        logic [NI-1:0] int_ack;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: mode 0 reset,1 first fetch,2 second word,3 return wait,4 irq entry
    int            m_mode  = 0;
    int            m_wleft = WC;
    logic          m_loaded = 1'b0;
    logic [NI-1:0] m_pend  = '0;
    int            m_perf  = 0;

    task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
        end
    endtask

    task automatic chk_exp(input string tag, input exp_t a, input exp_t e);
        chk({tag, ".pc_en"},    16'(a.pc_en),    16'(e.pc_en));
        chk({tag, ".pc_load"},  16'(a.pc_load),  16'(e.pc_load));
        chk({tag, ".stall"},    16'(a.stall),    16'(e.stall));
        chk({tag, ".sf1"},      16'(a.sf1),      16'(e.sf1));
        chk({tag, ".pc_src"},   16'(a.pc_src),   16'(e.pc_src));
        chk({tag, ".addr_src"}, 16'(a.addr_src), 16'(e.addr_src));
        chk({tag, ".int_ack"},  16'(a.int_ack),  16'(e.int_ack));
    endtask

    function automatic exp_t sample();
        exp_t s;
        s.pc_en    = b.pc_en;
        s.pc_load  = b.pc_load;
        s.stall    = b.stall;
        s.sf1      = b.sf1;
        s.pc_src   = b.pc_src;
        s.addr_src = b.addr_src;
        s.int_ack  = b.int_ack;
        return s;
    endfunction

    function automatic exp_t rst_exp();
        exp_t e = '0;
        e.pc_en    = 1'b1;
        e.pc_load  = 1'b1;
        e.pc_src   = 2'b01;
        e.addr_src = AW'(1);
        return e;
    endfunction

    task automatic model(input stim_t s, output exp_t e);
        int nm;
        int k;
        e  = '0;
        nm = m_mode;
        if (s.rst) begin
            e = rst_exp();
            m_mode = 0; m_wleft = WC; m_loaded = 1'b0; m_pend = '0; m_perf = 0;
            return;
        end
        case (m_mode)
            0: begin e = rst_exp(); nm = 1; end
            1: begin
                if (s.bt) begin
                    e.pc_en = 1; e.pc_load = 1; e.pc_src = 2'b00;
                end else if (s.opcode == 4'd11 && s.brx >= 2) begin
                    e.stall = 1; nm = 3;
                end else if (s.opcode == 4'd11) begin
                    if (s.byp) begin e.pc_en = 1; e.pc_load = 1; e.pc_src = 2'b10; end
                    else e.stall = 1;
                end else if (s.irq_en && m_pend != 0) begin
                    nm = 4;
                end else begin
                    e.pc_en = !m_loaded;
                    nm = (s.opcode == 4'd12) ? 2 : 1;
                end
                if (s.stall_in) begin e.pc_en = 0; e.pc_load = 0; nm = 1; end
            end
            2: begin
                e.pc_en = 1; nm = 1;
                if (s.stall_in) begin e.pc_en = 0; nm = 2; end
            end
            3: begin
                e.stall = 1;
                if (!s.stall_in) begin
                    if (m_wleft == 1) begin
                        e.pc_en = 1; e.pc_load = 1; e.pc_src = 2'b11; e.stall = 0;
                        nm = 1; m_wleft = WC;
                    end else begin
                        m_wleft--;
                    end
                end
            end
            default: begin
                k = 0;
                for (int i = NI - 1; i >= 0; i--) if (m_pend[i]) k = i;
                e.pc_en = 1; e.pc_load = 1; e.pc_src = 2'b01; e.sf1 = 1;
                e.addr_src = AW'(2 + k);
                e.int_ack[k] = 1'b1;
                nm = 1;
            end
        endcase
        m_pend   = (m_pend & ~e.int_ack) | s.irq;
        m_loaded = e.pc_load;
        m_mode   = nm;
        if (e.stall && m_perf < 65535) m_perf++;
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        reset                = s.rst;
        b.irq                = s.irq;
        b.irq_en             = s.irq_en;
        b.stall_in           = s.stall_in;
        b.opcode             = s.opcode;
        b.brx                = s.brx;
        b.branch_taken       = s.bt;
        b.bypass_decode_done = s.byp;
        model(s, e);
        q.push_back(e);
    endtask

    function automatic stim_t rnd();
        stim_t s = '0;
        int r;
        s.rst = ($urandom_range(0, 199) == 0);
        for (int i = 0; i < NI; i++) s.irq[i] = ($urandom_range(0, 19) == 0);
        s.irq_en   = ($urandom_range(0, 9) < 7);
        s.stall_in = ($urandom_range(0, 4) == 0);
        r = int'($urandom_range(0, 9));
        s.opcode   = (r < 2) ? 4'd11 : (r == 2) ? 4'd12 : 4'($urandom_range(0, 15));
        s.brx      = 2'($urandom_range(0, 3));
        s.bt       = ($urandom_range(0, 9) == 0);
        s.byp      = 1'($urandom_range(0, 1));
        return s;
    endfunction

    // Monitor: outputs are valid every cycle, compared mid-cycle against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) chk_exp("cycle", sample(), q.pop_front());
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        b.irq = '0; b.irq_en = 0; b.stall_in = 0; b.opcode = '0; b.brx = '0;
        b.branch_taken = 0; b.bypass_decode_done = 0;

        // reset release: load reset vector, then loaded_q blocks one pc_en
        s = '0; s.rst = 1;
        step(s); step(s);
        s.rst = 0;
        repeat (3) step(s);

        // two-word instruction with stall held in FETCH2
        s.opcode = 4'd12; step(s);
        s.opcode = 4'd0; s.stall_in = 1; repeat (3) step(s);
        s.stall_in = 0; repeat (2) step(s);

        // RET with a single stall pulse inside WAIT
        s.opcode = 4'd11; s.brx = 2'd2; step(s);
        s.opcode = 4'd0; s.brx = 2'd0; s.stall_in = 1; step(s);
        s.stall_in = 0; repeat (4) step(s);

        // two pending sources, lowest first
        s.irq = 4'b1010; s.irq_en = 1; step(s);
        s.irq = '0; repeat (7) step(s);

        // branch beats pending irq and RET; irq_en low keeps pend parked
        s.irq = 4'b0100; s.irq_en = 0; step(s);
        s.irq = '0; repeat (4) step(s);
        s.irq_en = 1; s.bt = 1; s.opcode = 4'd11; s.brx = 2'd3; step(s);
        s.bt = 0; s.opcode = 4'd0; s.brx = 2'd0; repeat (4) step(s);

        // JMP waiting on operand, then resolved
        s.opcode = 4'd11; s.brx = 2'd1; s.byp = 0; repeat (2) step(s);
        s.byp = 1; step(s);
        s.opcode = 4'd0; s.byp = 0; repeat (2) step(s);

        // async reset in the middle of WAIT with an irq pending
        s.irq_en = 0; s.irq = 4'b0001; s.opcode = 4'd11; s.brx = 2'd2; step(s);
        s.irq = '0; s.opcode = 4'd0; s.brx = 2'd0; step(s);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_exp("async_reset", sample(), rst_exp());
        s.rst = 1; step(s);
        s.rst = 0; s.irq_en = 1; repeat (5) step(s);

        repeat (3000) step(rnd());

        s = '0; step(s);
        repeat (2) @(negedge clk);
        chk("queue_drained", 16'(q.size()), 16'd0);
`ifdef PC_SEQ_PERF_CNT_EN
        chk("perf_stall_cnt", perf, 16'(m_perf));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter NUM_IRQ, default 4: number of interrupt sources, 1..8.
REQ-002 Parameter WAIT_CYCLES, default 2: RET/RTI memory wait length in unstalled cycles, range 1..7.
REQ-003 Parameter EXT_OPC, default 4'd12: opcode of two-word instructions (LDM/LDD/STD).
REQ-004 One clock; reset is asynchronous and active-high (ports clk, reset).
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 irq  in  NUM_IRQ  interrupt requests, level-sampled each cycle.
REQ-008 irq_en  in  1  global interrupt enable.
REQ-009 stall_in  in  1  downstream stall.
REQ-010 opcode  in  4  decoded opcode.
REQ-011 brx  in  2  branch sub-op: <2 is JMP/CALL, >=2 is RET/RTI (opcode 4'd11).
REQ-012 branch_taken  in  1  conditional branch/LOOP resolved taken.
REQ-013 bypass_decode_done  in  1  JMP/CALL target operand valid.
REQ-014 pc_en, pc_load, stall, sf1  out  1 each  PC enable, PC load, fetch stall, push-PC select.
REQ-015 pc_src  out  2  00 R[rb]ex, 01 vector memory, 10 R[rb]d, 11 data_out.
REQ-016 addr_src  out  $clog2(NUM_IRQ+2)  0 PC fetch, 1 reset vector M[0], 2+k IRQ k vector M[1+k].
REQ-017 int_ack  out  NUM_IRQ  one-hot acknowledge, one cycle.

Function
REQ-018 States SEQ_RESET, FETCH1, FETCH2, WAIT, IRQ; all outputs are combinational from state and inputs; defaults are 0.
REQ-019 SEQ_RESET: pc_en=1, pc_load=1, pc_src=01, addr_src=1; next state FETCH1.
REQ-020 FETCH1 priority, highest first: branch_taken, then RET/RTI, then JMP/CALL, then pending IRQ, then normal fetch.
REQ-021 FETCH1, branch_taken=1: pc_en=1, pc_load=1, pc_src=00; stay in FETCH1.
REQ-022 FETCH1, RET/RTI: stall=1, no PC update; next state WAIT.
REQ-023 FETCH1, JMP/CALL with bypass_decode_done=1: pc_en=1, pc_load=1, pc_src=10; with bypass_decode_done=0: stall=1 and hold FETCH1.
REQ-024 FETCH1 normal fetch: pc_en=1 unless loaded_q=1; next state FETCH2 if opcode==EXT_OPC, else FETCH1.
REQ-025 loaded_q is a register, set in any cycle with pc_load=1 and cleared otherwise.
REQ-026 stall_in=1 in FETCH1 or FETCH2 forces pc_en=0 and pc_load=0 and holds the state; branch and jump requests are re-evaluated in the next cycle.
REQ-027 FETCH2: pc_en=1; next state FETCH1.
REQ-028 WAIT: stall=1; wait counter increments on each stall_in=0 cycle.
REQ-029 WAIT exit: when counter==WAIT_CYCLES-1 and stall_in=0, drive pc_en=1, pc_load=1, pc_src=11, stall=0; next state FETCH1; counter clears.
REQ-030 pend register: pend <= (pend & ~int_ack) | irq; a set and a clear on the same bit in one cycle leave the bit set.
REQ-031 IRQ entry happens only from FETCH1 with no higher-priority request, stall_in=0, irq_en=1 and pend!=0; it never occurs in FETCH2, WAIT or IRQ.
REQ-032 IRQ state, one cycle: k is the lowest set pend bit; drive pc_en=1, pc_load=1, pc_src=01, addr_src=2+k, sf1=1, int_ack[k]=1; next state FETCH1.

Reset
REQ-033 Asserting reset asynchronously sets state to SEQ_RESET and clears pend, the wait counter and loaded_q; this applies at any point, including mid-WAIT and mid-FETCH2.
REQ-034 While reset is high, outputs equal the SEQ_RESET values; int_ack=0.

Configuration
REQ-035 With PC_SEQ_PERF_CNT_EN defined: add output perf_stall_cnt[15:0], which counts cycles with stall=1, saturates at 16'hFFFF and resets to 0.
REQ-036 Without PC_SEQ_PERF_CNT_EN: the port and the counter are absent, and all other behaviour is identical.

Structure
REQ-037 Shared package pc_seq_pkg holds the state encoding, the pc_src codes (PCSRC_REX, PCSRC_VEC, PCSRC_RD, PCSRC_MEM), OPC_BR=4'd11 and the default EXT_OPC.
REQ-038 Sub-module pc_seq_irq_arb, a parametrised lowest-index-first priority encoder (pend -> one-hot grant plus index), is instantiated once.

Verification
REQ-039 Release reset -> cycle 0: pc_load=1, addr_src=1; cycle 1: FETCH1 with pc_en=0 (loaded_q); cycle 2: pc_en=1.
REQ-040 opcode=12 in FETCH1 -> FETCH2 with pc_en=1 -> FETCH1; stall_in=1 in FETCH2 for 3 cycles -> pc_en=0 and state held.
REQ-041 RET with WAIT_CYCLES=2 and stall_in pulsed once in WAIT -> stall=1 for 3 cycles, then pc_load=1 with pc_src=11.
REQ-042 irq=4'b1010, irq_en=1, normal FETCH1 -> IRQ with addr_src=3, int_ack=4'b0010, sf1=1; later boundary -> addr_src=5, int_ack=4'b1000.
REQ-043 branch_taken=1 together with irq pending and RET opcode -> pc_src=00 taken and IRQ deferred; irq_en=0 -> IRQ never entered, pend retained.
REQ-044 Reset asserted mid-WAIT -> outputs switch to SEQ_RESET values immediately, asynchronously to clk, and pend=0.
